debouncer_multi: RTL and testbench

//   Parametrised N-channel button debouncer; successor to the single-channel debouncer.
//   Per channel: synchronises a raw async input and filters contact bounce.

---
 rtl/debouncer_multi.sv | 167 ++++++++++++++++
 tb/tb_debouncer_multi.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debouncer_multi.sv
// N-channel button debouncer: per-channel synchroniser, stability filter,
// registered press/release pulses and optional auto-repeat while held.
module debouncer_multi #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DEBOUNCE_CNT = 65535,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned REPEAT_EN    = 0,
  parameter int unsigned RPT_W        = 24,
  parameter int unsigned REPEAT_DELAY = 1000,
  parameter int unsigned REPEAT_RATE  = 250
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_state,
  output logic [N_CH-1:0] btn_pressed,
  output logic [N_CH-1:0] btn_released,
  output logic [N_CH-1:0] btn_repeat
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic [N_CH-1:0]  sync_q [SYNC_STAGES];
  logic [N_CH-1:0]  sync_d [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q  [N_CH];
  logic [CNT_W-1:0] cnt_d  [N_CH];
  logic [N_CH-1:0]  state_q, state_d;
  logic [N_CH-1:0]  pressed_q, pressed_d;
  logic [N_CH-1:0]  released_q, released_d;
  logic [N_CH-1:0]  s;

  always_comb begin
    sync_d[0] = btn_in;
    for (int unsigned st = 1; st < SYNC_STAGES; st++) begin
      sync_d[st] = sync_q[st-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Any sample equal to the current level restarts the count; no partial credit.
  always_comb begin
    state_d = state_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (s[i] != state_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          state_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    pressed_d  = state_d & ~state_q;
    released_d = ~state_d & state_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned st = 0; st < SYNC_STAGES; st++) begin
        sync_q[st] <= '0;
      end
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
      state_q    <= '0;
      pressed_q  <= '0;
      released_q <= '0;
    end else begin
      for (int unsigned st = 0; st < SYNC_STAGES; st++) begin
        sync_q[st] <= sync_d[st];
      end
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q    <= state_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  assign btn_state    = state_q;
  assign btn_pressed  = pressed_q;
  assign btn_released = released_q;

  if (REPEAT_EN != 0) begin : g_repeat
    typedef enum logic [1:0] {
      RPT_IDLE,
      RPT_DELAY,
      RPT_REPEAT
    } rpt_state_e;

    localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RR_LAST = RPT_W'(REPEAT_RATE - 1);

    rpt_state_e       rpt_q  [N_CH];
    rpt_state_e       rpt_d  [N_CH];
    logic [RPT_W-1:0] hold_q [N_CH];
    logic [RPT_W-1:0] hold_d [N_CH];
    logic [N_CH-1:0]  repeat_q, repeat_d;

    // Keyed on next-cycle level so the FSM is already idle in the release cycle.
    always_comb begin
      repeat_d = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        rpt_d[i]  = rpt_q[i];
        hold_d[i] = hold_q[i];
        if (!state_d[i]) begin
          rpt_d[i]  = RPT_IDLE;
          hold_d[i] = '0;
        end else begin
          case (rpt_q[i])
            RPT_IDLE: begin
              if (pressed_d[i]) begin
                rpt_d[i]  = RPT_DELAY;
                hold_d[i] = '0;
              end
            end
            RPT_DELAY: begin
              if (hold_q[i] == RD_LAST) begin
                repeat_d[i] = 1'b1;
                hold_d[i]   = '0;
                rpt_d[i]    = RPT_REPEAT;
              end else if (hold_q[i] != '1) begin
                hold_d[i] = hold_q[i] + 1'b1;
              end
            end
            RPT_REPEAT: begin
              if (hold_q[i] == RR_LAST) begin
                repeat_d[i] = 1'b1;
                hold_d[i]   = '0;
              end else if (hold_q[i] != '1) begin
                hold_d[i] = hold_q[i] + 1'b1;
              end
            end
            default: begin
              rpt_d[i]  = RPT_IDLE;
              hold_d[i] = '0;
            end
          endcase
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int unsigned i = 0; i < N_CH; i++) begin
          rpt_q[i]  <= RPT_IDLE;
          hold_q[i] <= '0;
        end
        repeat_q <= '0;
      end else begin
        for (int unsigned i = 0; i < N_CH; i++) begin
          rpt_q[i]  <= rpt_d[i];
          hold_q[i] <= hold_d[i];
        end
        repeat_q <= repeat_d;
      end
    end

    assign btn_repeat = repeat_q;
  end else begin : g_no_repeat
    assign btn_repeat = '0;
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi: latency, bounce rejection, release,
// auto-repeat timing, reset mid-count and simultaneous channels.
module tb_debouncer_multi;

  logic       clk;
  logic       reset;
  logic [1:0] btn_in;
  logic [1:0] btn_state;
  logic [1:0] btn_pressed;
  logic [1:0] btn_released;
  logic [1:0] btn_repeat;

  int total = 0;
  int bad   = 0;

  debouncer_multi #(
    .N_CH        (2),
    .DEBOUNCE_CNT(16),
    .SYNC_STAGES (2),
    .REPEAT_EN   (1),
    .REPEAT_DELAY(20),
    .REPEAT_RATE (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .btn_state   (btn_state),
    .btn_pressed (btn_pressed),
    .btn_released(btn_released),
    .btn_repeat  (btn_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int e = 0; e < 3; e++) begin
      tick();
      total++;
      if ({btn_state, btn_pressed, btn_released, btn_repeat} !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold: got %b want 00000000",
                 {btn_state, btn_pressed, btn_released, btn_repeat});
      end
    end
    reset = 1'b1;
    for (int e = 0; e < 2; e++) begin
      tick();
      total++;
      if ({btn_state, btn_pressed, btn_released, btn_repeat} !== 8'h00) begin
        bad++;
        $display("FAIL reset_idle: got %b want 00000000",
                 {btn_state, btn_pressed, btn_released, btn_repeat});
      end
    end
  endtask

  task automatic test_clean_press();
    btn_in = 2'b01;
    for (int e = 1; e <= 17; e++) begin
      tick();
      total++;
      if ({btn_state, btn_pressed} !== 4'b0000) begin
        bad++;
        $display("FAIL press_early edge %0d: state/pressed got %b want 0000", e, {btn_state, btn_pressed});
      end
    end
    tick();
    total++;
    if (btn_state !== 2'b01) begin
      bad++;
      $display("FAIL press_state: got %b want 01", btn_state);
    end
    total++;
    if (btn_pressed !== 2'b01) begin
      bad++;
      $display("FAIL press_pulse: got %b want 01", btn_pressed);
    end
    total++;
    if ({btn_released, btn_repeat} !== 4'b0000) begin
      bad++;
      $display("FAIL press_other: released/repeat got %b want 0000", {btn_released, btn_repeat});
    end
    tick();
    total++;
    if ({btn_state, btn_pressed} !== 4'b0100) begin
      bad++;
      $display("FAIL press_after: state/pressed got %b want 0100", {btn_state, btn_pressed});
    end
  endtask

  // Continues from the press: k counts edges since the press pulse edge.
  task automatic test_auto_repeat();
    logic [1:0] exp_rep;
    for (int k = 2; k <= 60; k++) begin
      tick();
      exp_rep = (k >= 20 && (k - 20) % 5 == 0) ? 2'b01 : 2'b00;
      total++;
      if (btn_repeat !== exp_rep) begin
        bad++;
        $display("FAIL repeat k=%0d: got %b want %b", k, btn_repeat, exp_rep);
      end
      total++;
      if ({btn_state, btn_pressed} !== 4'b0100) begin
        bad++;
        $display("FAIL repeat_hold k=%0d: state/pressed got %b want 0100", k, {btn_state, btn_pressed});
      end
    end
  endtask

  task automatic test_release();
    logic [1:0] exp_rep;
    int         k;
    btn_in = 2'b00;
    for (int j = 1; j <= 17; j++) begin
      tick();
      k = 60 + j;
      exp_rep = ((k - 20) % 5 == 0) ? 2'b01 : 2'b00;
      total++;
      if ({btn_state, btn_released, btn_repeat} !== {4'b0100, exp_rep}) begin
        bad++;
        $display("FAIL release_wait k=%0d: state/rel/rep got %b want %b",
                 k, {btn_state, btn_released, btn_repeat}, {4'b0100, exp_rep});
      end
    end
    tick();
    total++;
    if ({btn_state, btn_released, btn_repeat} !== 6'b000100) begin
      bad++;
      $display("FAIL release_pulse: state/rel/rep got %b want 000100",
               {btn_state, btn_released, btn_repeat});
    end
    for (int j = 0; j < 5; j++) begin
      tick();
      total++;
      if ({btn_state, btn_pressed, btn_released, btn_repeat} !== 8'h00) begin
        bad++;
        $display("FAIL release_after: got %b want 00000000",
                 {btn_state, btn_pressed, btn_released, btn_repeat});
      end
    end
  endtask

  task automatic test_bounce();
    for (int seg = 0; seg < 20; seg++) begin
      btn_in = (seg % 2 == 0) ? 2'b01 : 2'b00;
      for (int c = 0; c < 5; c++) begin
        tick();
        total++;
        if ({btn_state, btn_pressed, btn_released} !== 6'b000000) begin
          bad++;
          $display("FAIL bounce seg=%0d: state/pr/rel got %b want 000000",
                   seg, {btn_state, btn_pressed, btn_released});
        end
      end
    end
    btn_in = 2'b01;
    for (int e = 1; e <= 17; e++) begin
      tick();
      total++;
      if ({btn_state, btn_pressed} !== 4'b0000) begin
        bad++;
        $display("FAIL bounce_settle edge %0d: got %b want 0000", e, {btn_state, btn_pressed});
      end
    end
    tick();
    total++;
    if ({btn_state, btn_pressed} !== 4'b0101) begin
      bad++;
      $display("FAIL bounce_press: state/pressed got %b want 0101", {btn_state, btn_pressed});
    end
    btn_in = 2'b00;
    for (int e = 1; e <= 17; e++) begin
      tick();
      total++;
      if ({btn_pressed, btn_released, btn_repeat} !== 6'b000000) begin
        bad++;
        $display("FAIL bounce_once edge %0d: pr/rel/rep got %b want 000000",
                 e, {btn_pressed, btn_released, btn_repeat});
      end
    end
    tick();
    total++;
    if ({btn_state, btn_released} !== 4'b0001) begin
      bad++;
      $display("FAIL bounce_release: state/rel got %b want 0001", {btn_state, btn_released});
    end
  endtask

  task automatic test_reset_mid_count();
    tick();
    btn_in = 2'b01;
    for (int e = 0; e < 12; e++) tick();
    reset = 1'b0;
    #1;
    total++;
    if ({btn_state, btn_pressed, btn_released, btn_repeat} !== 8'h00) begin
      bad++;
      $display("FAIL midreset_async: got %b want 00000000",
               {btn_state, btn_pressed, btn_released, btn_repeat});
    end
    for (int e = 0; e < 3; e++) begin
      tick();
      total++;
      if ({btn_state, btn_pressed, btn_released, btn_repeat} !== 8'h00) begin
        bad++;
        $display("FAIL midreset_hold: got %b want 00000000",
                 {btn_state, btn_pressed, btn_released, btn_repeat});
      end
    end
    reset = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      tick();
      total++;
      if ({btn_state, btn_pressed} !== 4'b0000) begin
        bad++;
        $display("FAIL midreset_early edge %0d: got %b want 0000", e, {btn_state, btn_pressed});
      end
    end
    tick();
    total++;
    if ({btn_state, btn_pressed} !== 4'b0101) begin
      bad++;
      $display("FAIL midreset_press: state/pressed got %b want 0101", {btn_state, btn_pressed});
    end
    btn_in = 2'b00;
    for (int e = 0; e < 18; e++) tick();
    total++;
    if ({btn_state, btn_released} !== 4'b0001) begin
      bad++;
      $display("FAIL midreset_release: state/rel got %b want 0001", {btn_state, btn_released});
    end
  endtask

  task automatic test_simultaneous();
    tick();
    btn_in = 2'b11;
    for (int e = 1; e <= 17; e++) begin
      tick();
      total++;
      if ({btn_state, btn_pressed} !== 4'b0000) begin
        bad++;
        $display("FAIL simul_early edge %0d: got %b want 0000", e, {btn_state, btn_pressed});
      end
    end
    tick();
    total++;
    if ({btn_state, btn_pressed} !== 4'b1111) begin
      bad++;
      $display("FAIL simul_press: state/pressed got %b want 1111", {btn_state, btn_pressed});
    end
    btn_in = 2'b01;
    for (int e = 1; e <= 17; e++) begin
      tick();
      total++;
      if ({btn_state, btn_released} !== 4'b1100) begin
        bad++;
        $display("FAIL simul_wait edge %0d: state/rel got %b want 1100", e, {btn_state, btn_released});
      end
    end
    tick();
    total++;
    if ({btn_state, btn_released, btn_repeat} !== 6'b011000) begin
      bad++;
      $display("FAIL simul_release: state/rel/rep got %b want 011000",
               {btn_state, btn_released, btn_repeat});
    end
    btn_in = 2'b00;
    for (int e = 0; e < 18; e++) tick();
    total++;
    if ({btn_state, btn_released, btn_repeat} !== 6'b000100) begin
      bad++;
      $display("FAIL simul_final: state/rel/rep got %b want 000100",
               {btn_state, btn_released, btn_repeat});
    end
  endtask

  initial begin
    reset  = 1'b0;
    btn_in = 2'b00;
    test_reset();
    test_clean_press();
    test_auto_repeat();
    test_release();
    test_bounce();
    test_reset_mid_count();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
